lstm_stream_feeder: RTL and testbench



---
 rtl/lstm_stream_feeder.sv | 152 +++++++++++++++
 tb/tb_lstm_stream_feeder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_stream_feeder.sv
// Streaming feeder for the LSTM core: input FIFO, one-sample-in-flight issue, output FIFO with sequence-last marking.
// Optional watchdog is compiled in with `define LSTM_FEEDER_TIMEOUT_EN.
module lstm_stream_feeder #(
    parameter int WIDTH          = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [15:0]        seq_len,
    output logic [WIDTH-1:0]   x_in,
    output logic               x_in_valid,
    input  logic               lstm_ready,
    input  logic [WIDTH-1:0]   y_out,
    input  logic [WIDTH-1:0]   C_out,
    input  logic               lstm_valid,
    output logic [2*WIDTH-1:0] m_data,
    output logic               m_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               busy,
    output logic               error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = 2 * WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
        $error("lstm_stream_feeder: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x_in_q;
    logic             x_in_valid_q;

    logic [WIDTH-1:0] in_mem [FIFO_DEPTH];
    logic [AW-1:0]    in_wr_q, in_rd_q;
    logic [CW-1:0]    in_cnt_q;
    logic [OW-1:0]    out_mem [FIFO_DEPTH];
    logic [AW-1:0]    out_wr_q, out_rd_q;
    logic [CW-1:0]    out_cnt_q;
    logic [15:0]      seq_cnt_q, seq_cnt_d, last_idx;
    logic             in_push, in_pop, out_push, out_pop, issue, capture, is_last;

    assign s_ready  = (in_cnt_q != DEPTH_C);
    assign in_push  = s_valid && s_ready;
    // Credit rule: the core cannot be stalled, so only issue when the result has somewhere to land.
    assign issue    = (state_q == IDLE) && (in_cnt_q != '0) && lstm_ready && (out_cnt_q != DEPTH_C);
    assign in_pop   = issue;
    assign capture  = (state_q == WAIT) && lstm_valid;
    assign out_push = capture;
    assign m_valid  = (out_cnt_q != '0);
    assign out_pop  = m_valid && m_ready;

    assign last_idx  = (seq_len == 16'd0) ? 16'd0 : seq_len - 16'd1;
    assign is_last   = (seq_cnt_q == last_idx);
    assign seq_cnt_d = is_last ? 16'd0 : seq_cnt_q + 16'd1;

    assign m_data     = m_valid ? out_mem[out_rd_q][2*WIDTH-1:0] : '0;
    assign m_last     = m_valid && out_mem[out_rd_q][2*WIDTH];
    assign x_in       = x_in_q;
    assign x_in_valid = x_in_valid_q;
    assign busy       = (state_q != IDLE) || (in_cnt_q != '0);

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wr_q] <= s_data;
        if (out_push) out_mem[out_wr_q] <= {is_last, C_out, y_out};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            in_cnt_q  <= '0;
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
            seq_cnt_q <= '0;
        end else begin
            if (in_push) in_wr_q <= in_wr_q + AW'(1);
            if (in_pop) in_rd_q <= in_rd_q + AW'(1);
            case ({in_push, in_pop})
                2'b10:   in_cnt_q <= in_cnt_q + CW'(1);
                2'b01:   in_cnt_q <= in_cnt_q - CW'(1);
                default: ;
            endcase
            if (out_push) out_wr_q <= out_wr_q + AW'(1);
            if (out_pop) out_rd_q <= out_rd_q + AW'(1);
            case ({out_push, out_pop})
                2'b10:   out_cnt_q <= out_cnt_q + CW'(1);
                2'b01:   out_cnt_q <= out_cnt_q - CW'(1);
                default: ;
            endcase
            if (capture) seq_cnt_q <= seq_cnt_d;
        end
    end

`ifdef LSTM_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TLIM_C = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_q;
    logic          error_q;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            x_in_q       <= '0;
            x_in_valid_q <= 1'b0;
`ifdef LSTM_FEEDER_TIMEOUT_EN
            timer_q      <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            x_in_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        x_in_q       <= in_mem[in_rd_q];
                        x_in_valid_q <= 1'b1;
                        state_q      <= WAIT;
`ifdef LSTM_FEEDER_TIMEOUT_EN
                        timer_q      <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (lstm_valid) begin
                        state_q <= IDLE;
`ifdef LSTM_FEEDER_TIMEOUT_EN
                    end else if (timer_q == TLIM_C) begin
                        // Abandon the lost result; a late strobe lands in IDLE and is dropped.
                        state_q <= IDLE;
                        error_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lstm_stream_feeder.sv
// Bench for lstm_stream_feeder: random samples, a behavioural core, and queue-based expectations.
module tb_lstm_stream_feeder;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   s_data;
    logic           s_valid;
    logic           s_ready;
    logic [15:0]    seq_len;
    logic [W-1:0]   x_in;
    logic           x_in_valid;
    logic           lstm_ready;
    logic [W-1:0]   y_out;
    logic [W-1:0]   C_out;
    logic           lstm_valid;
    logic [2*W-1:0] m_data;
    logic           m_last;
    logic           m_valid;
    logic           m_ready;
    logic           busy;
    logic           error;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [15:0] core_xor = 16'h0, core_add = 16'h0;
    int          core_lat = 3;
    bit          core_mute = 1'b0;

    logic [15:0] acc_q[$];
    int          acc_cyc_q[$];
    logic [15:0] iss_q[$];
    int          iss_cyc_q[$];
    logic [32:0] rcv_q[$];
    int          rcv_cyc_q[$];
    int          lv_cyc_q[$];

    lstm_stream_feeder #(.WIDTH(W), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .seq_len(seq_len), .x_in(x_in), .x_in_valid(x_in_valid), .lstm_ready(lstm_ready),
        .y_out(y_out), .C_out(C_out), .lstm_valid(lstm_valid), .m_data(m_data),
        .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_valid && s_ready) begin acc_q.push_back(s_data); acc_cyc_q.push_back(cyc); end
        if (x_in_valid) begin iss_q.push_back(x_in); iss_cyc_q.push_back(cyc); end
        if (m_valid && m_ready) begin rcv_q.push_back({m_last, m_data}); rcv_cyc_q.push_back(cyc); end
        if (lstm_valid) lv_cyc_q.push_back(cyc);
    end

    // Behavioural LSTM core: answers core_lat cycles after each strobe.
    initial begin
        logic [15:0] x;
        lstm_valid = 1'b0;
        y_out = '0;
        C_out = '0;
        forever begin
            @(negedge clk);
            if (x_in_valid && !core_mute) begin
                x = x_in;
                repeat (core_lat) @(posedge clk);
                #1;
                y_out = x ^ core_xor;
                C_out = x + core_add;
                lstm_valid = 1'b1;
                @(posedge clk);
                #1 lstm_valid = 1'b0;
            end
        end
    end

    function automatic logic [32:0] expect_res(input logic [15:0] x, input bit last);
        logic [15:0] c, y;
        c = x + core_add;
        y = x ^ core_xor;
        return {last, c, y};
    endfunction

    function automatic bit exp_last(input int k, input int len);
        int l;
        l = (len == 0) ? 1 : len;
        return (k % l) == (l - 1);
    endfunction

    task automatic clear_q();
        acc_q.delete(); acc_cyc_q.delete(); iss_q.delete(); iss_cyc_q.delete();
        rcv_q.delete(); rcv_cyc_q.delete(); lv_cyc_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        int t;
        t = 0;
        s_data = d;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && t < 300) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int t;
        t = 0;
        while (rcv_q.size() < n && t < budget) begin tick(1); t++; end
    endtask

    task automatic wait_issues(input int n, input int budget);
        int t;
        t = 0;
        while (iss_q.size() < n && t < budget) begin tick(1); t++; end
    endtask

    task automatic test_reset();
        logic [31:0] obs [8];
        logic [31:0] req [8];
        string nm [8];
        rst = 1'b1;
        tick(3);
        obs = '{32'(s_ready), 32'(x_in), 32'(x_in_valid), 32'(m_valid), 32'(m_last), m_data, 32'(busy), 32'(error)};
        req = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        nm  = '{"s_ready", "x_in", "x_in_valid", "m_valid", "m_last", "m_data", "busy", "error"};
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (obs[i] !== req[i]) begin
                miscompares++;
                $display("FAIL reset_%s got %h want %h", nm[i], obs[i], req[i]);
            end
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single();
        seq_len = 16'd1; core_lat = 5; core_xor = 16'h0140; core_add = 16'hFF80;
        clear_q();
        send(16'h0100);
        wait_results(1, 60);
        vectors++;
        if (iss_q.size() !== 1) begin miscompares++; $display("FAIL single_issue_count got %0d want 1", iss_q.size()); end
        vectors++;
        if (iss_cyc_q[0] !== acc_cyc_q[0] + 2) begin
            miscompares++; $display("FAIL single_issue_cycle got %0d want %0d", iss_cyc_q[0], acc_cyc_q[0] + 2);
        end
        vectors++;
        if (iss_q[0] !== 16'h0100) begin miscompares++; $display("FAIL single_x_in got %h want 0100", iss_q[0]); end
        vectors++;
        if (rcv_q.size() !== 1) begin miscompares++; $display("FAIL single_result_count got %0d want 1", rcv_q.size()); end
        vectors++;
        if (rcv_cyc_q[0] !== lv_cyc_q[0] + 1) begin
            miscompares++; $display("FAIL single_result_cycle got %0d want %0d", rcv_cyc_q[0], lv_cyc_q[0] + 1);
        end
        vectors++;
        if (rcv_q[0] !== {1'b1, 32'h00800040}) begin
            miscompares++; $display("FAIL single_result got %h want %h", rcv_q[0], {1'b1, 32'h00800040});
        end
        vectors++;
        if (x_in !== 16'h0100) begin miscompares++; $display("FAIL single_x_in_hold got %h want 0100", x_in); end
    endtask

    task automatic test_burst();
        seq_len = 16'd1; core_lat = $urandom_range(1, 4);
        core_xor = 16'($urandom); core_add = 16'($urandom);
        clear_q();
        lstm_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'($urandom));
        s_data = 16'($urandom);
        s_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b0 || acc_q.size() !== 8) begin
            miscompares++; $display("FAIL burst_full s_ready %b accepted %0d want 0 and 8", s_ready, acc_q.size());
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
        lstm_ready = 1'b1;
        send(16'($urandom));
        send(16'($urandom));
        wait_results(10, 400);
        vectors++;
        if (iss_q.size() !== 10 || rcv_q.size() !== 10) begin
            miscompares++; $display("FAIL burst_counts issued %0d results %0d want 10 and 10", iss_q.size(), rcv_q.size());
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (iss_q[i] !== acc_q[i] || rcv_q[i] !== expect_res(acc_q[i], 1'b1)) begin
                miscompares++;
                $display("FAIL burst_item[%0d] issued %h result %h want %h %h", i, iss_q[i], rcv_q[i], acc_q[i], expect_res(acc_q[i], 1'b1));
            end
        end
    endtask

    task automatic test_backpressure();
        seq_len = 16'd1; core_lat = $urandom_range(1, 4);
        core_xor = 16'($urandom); core_add = 16'($urandom);
        clear_q();
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(16'($urandom));
        wait_issues(8, 200);
        tick(30);
        vectors++;
        if (iss_q.size() !== 8) begin miscompares++; $display("FAIL bp_withheld issued %0d want 8", iss_q.size()); end
        vectors++;
        if (m_valid !== 1'b1 || {m_last, m_data} !== expect_res(acc_q[0], 1'b1)) begin
            miscompares++; $display("FAIL bp_head m_valid %b data %h want 1 %h", m_valid, {m_last, m_data}, expect_res(acc_q[0], 1'b1));
        end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy got %b want 1", busy); end
        m_ready = 1'b1;
        wait_results(12, 400);
        vectors++;
        if (rcv_q.size() !== 12) begin miscompares++; $display("FAIL bp_result_count got %0d want 12", rcv_q.size()); end
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (rcv_q[i] !== expect_res(acc_q[i], 1'b1)) begin
                miscompares++; $display("FAIL bp_result[%0d] got %h want %h", i, rcv_q[i], expect_res(acc_q[i], 1'b1));
            end
        end
    endtask

    task automatic test_seq_len(input int len, input int n);
        seq_len = 16'(len); core_lat = $urandom_range(1, 4);
        core_xor = 16'($urandom); core_add = 16'($urandom);
        clear_q();
        for (int i = 0; i < n; i++) send(16'($urandom));
        wait_results(n, 300);
        vectors++;
        if (rcv_q.size() !== n) begin miscompares++; $display("FAIL seq%0d_count got %0d want %0d", len, rcv_q.size(), n); end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (rcv_q[i] !== expect_res(acc_q[i], exp_last(i, len))) begin
                miscompares++;
                $display("FAIL seq%0d_result[%0d] got %h want %h", len, i, rcv_q[i], expect_res(acc_q[i], exp_last(i, len)));
            end
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] obs [8];
        string nm [8];
        seq_len = 16'd1; core_lat = 10;
        core_xor = 16'($urandom); core_add = 16'($urandom);
        clear_q();
        send(16'($urandom));
        wait_issues(1, 50);
        tick(2);
        rst = 1'b1;
        tick(2);
        obs = '{32'(s_ready), 32'(x_in), 32'(x_in_valid), 32'(m_valid), 32'(m_last), m_data, 32'(busy), 32'(error)};
        nm  = '{"s_ready", "x_in", "x_in_valid", "m_valid", "m_last", "m_data", "busy", "error"};
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (obs[i] !== ((i == 0) ? 32'd1 : 32'd0)) begin
                miscompares++; $display("FAIL rstwait_%s got %h want %h", nm[i], obs[i], (i == 0) ? 32'd1 : 32'd0);
            end
        end
        rst = 1'b0;
        tick(15);
        vectors++;
        if (rcv_q.size() !== 0 || m_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rstwait_stale results %0d m_valid %b busy %b want 0 0 0", rcv_q.size(), m_valid, busy);
        end
        core_lat = 3;
        clear_q();
        send(16'($urandom));
        wait_results(1, 60);
        vectors++;
        if (rcv_q.size() !== 1 || rcv_q[0] !== expect_res(acc_q[0], 1'b1)) begin
            miscompares++; $display("FAIL rstwait_resume got %h want %h", rcv_q[0], expect_res(acc_q[0], 1'b1));
        end
    endtask

    task automatic test_watchdog();
        seq_len = 16'd1;
        core_xor = 16'($urandom); core_add = 16'($urandom);
        core_mute = 1'b1;
        clear_q();
        send(16'($urandom));
        wait_issues(1, 50);
`ifdef LSTM_FEEDER_TIMEOUT_EN
        tick(8);
        vectors++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL wd_early error %b busy %b want 0 1", error, busy);
        end
        tick(16);
        vectors++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL wd_fire error %b busy %b want 1 0", error, busy);
        end
        core_mute = 1'b0;
        core_lat = 2;
        clear_q();
        send(16'($urandom));
        wait_results(1, 60);
        vectors++;
        if (rcv_q.size() !== 1 || rcv_q[0] !== expect_res(acc_q[0], 1'b1) || error !== 1'b1) begin
            miscompares++; $display("FAIL wd_resume got %h error %b want %h 1", rcv_q[0], error, expect_res(acc_q[0], 1'b1));
        end
`else
        tick(40);
        vectors++;
        if (error !== 1'b0 || busy !== 1'b1 || rcv_q.size() !== 0) begin
            miscompares++; $display("FAIL wd_off error %b busy %b results %0d want 0 1 0", error, busy, rcv_q.size());
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        core_mute = 1'b0;
        tick(1);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL wd_off_recover busy %b want 0", busy); end
`endif
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; seq_len = 16'd1; lstm_ready = 1'b1; m_ready = 1'b1;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_seq_len(3, 7);
        test_reset_wait();
        test_seq_len(0, 5);
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
